// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage and register file.
package wb_pkg;

    localparam int unsigned WB_XLEN     = 64;
    localparam int unsigned WB_NUM_REGS = 32;
    localparam int unsigned WB_REG_AW   = $clog2(WB_NUM_REGS);
    localparam int unsigned WB_MAX_CH   = 4;

    typedef struct packed {
        logic                 valid;
        logic [WB_REG_AW-1:0] rd;
        logic [WB_XLEN-1:0]   aluresult;
        logic [WB_XLEN-1:0]   loaddata;
        logic                 dataselect;
    } wb_chan_t;

    typedef struct packed {
        logic                 valid;
        logic [WB_REG_AW-1:0] rd;
        logic [WB_XLEN-1:0]   rdval;
    } wb_fwd_t;

    function automatic logic [2:0] popcount4(input logic [WB_MAX_CH-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < int'(WB_MAX_CH); i++) begin
            if (v[i]) cnt = cnt + 3'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Read port with same-cycle bypass: youngest matching committing channel wins, x0 reads 0.
module wb_bypass_mux #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic [NUM_CH-1:0]             commit,
    input  logic [NUM_CH-1:0][REG_AW-1:0] rd,
    input  logic [NUM_CH-1:0][XLEN-1:0]   value,
    input  logic [REG_AW-1:0]             addr,
    input  logic [XLEN-1:0]               rf_data,
    output logic [XLEN-1:0]               data
);

    always_comb begin
        data = rf_data;
        // Ascending scan so the highest-index match overrides older ones.
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (commit[c] && (rd[c] == addr)) data = value[c];
        end
        if (addr == '0) data = '0;
    end

endmodule

// File: rtl/wb_multiport_regfile.sv
// Multi-channel writeback stage with integrated register file and registered EX forwarding.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_multiport_regfile
    import wb_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned NUM_RP   = 2,
    parameter int unsigned XLEN     = WB_XLEN,
    parameter int unsigned NUM_REGS = WB_NUM_REGS,
    parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             memwb_ready,
    input  logic [NUM_CH-1:0]                wb_valid,
    input  logic [NUM_CH-1:0][REG_AW-1:0]    wb_rd,
    input  logic [NUM_CH-1:0][XLEN-1:0]      wb_aluresult,
    input  logic [NUM_CH-1:0][XLEN-1:0]      wb_loaddata,
    input  logic [NUM_CH-1:0]                wb_dataselect,
    input  logic [NUM_RP-1:0][REG_AW-1:0]    rp_addr,
    output logic [NUM_RP-1:0][XLEN-1:0]      rp_data,
    output logic [NUM_CH-1:0]                wbex_valid,
    output logic [NUM_CH-1:0][REG_AW-1:0]    wbex_rd,
    output logic [NUM_CH-1:0][XLEN-1:0]      wbex_rdval,
    output logic                             wb_conflict
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]                      wb_retired
`endif
);

    logic [NUM_CH-1:0]              commit;
    logic [NUM_CH-1:0][XLEN-1:0]    value;
    logic                           conflict;
    logic [XLEN-1:0]                regs_q [NUM_REGS];
    logic [NUM_RP-1:0][XLEN-1:0]    rf_rdata;

    logic [NUM_CH-1:0]              wbex_valid_q;
    logic [NUM_CH-1:0][REG_AW-1:0]  wbex_rd_q;
    logic [NUM_CH-1:0][XLEN-1:0]    wbex_rdval_q;
    logic                           wb_conflict_q;

    // Writes to x0 carry value 0 so forwarding never leaks the discarded data.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            commit[c] = reset && memwb_ready && wb_valid[c];
            if (wb_rd[c] == '0) begin
                value[c] = '0;
            end else begin
                value[c] = wb_dataselect[c] ? wb_loaddata[c] : wb_aluresult[c];
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            for (int j = i + 1; j < int'(NUM_CH); j++) begin
                if (commit[i] && commit[j] && (wb_rd[i] == wb_rd[j]) && (wb_rd[i] != '0)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Later non-blocking writes win, giving the youngest channel priority on collisions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) regs_q[r] <= '0;
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (commit[c] && (wb_rd[c] != '0)) regs_q[wb_rd[c]] <= value[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wbex_valid_q  <= '0;
            wbex_rd_q     <= '0;
            wbex_rdval_q  <= '0;
            wb_conflict_q <= 1'b0;
        end else begin
            wbex_valid_q  <= commit;
            wb_conflict_q <= conflict;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (commit[c]) begin
                    wbex_rd_q[c]    <= wb_rd[c];
                    wbex_rdval_q[c] <= value[c];
                end
            end
        end
    end

    assign wbex_valid  = wbex_valid_q;
    assign wbex_rd     = wbex_rd_q;
    assign wbex_rdval  = wbex_rdval_q;
    assign wb_conflict = wb_conflict_q;

    always_comb begin
        for (int p = 0; p < int'(NUM_RP); p++) rf_rdata[p] = regs_q[rp_addr[p]];
    end

    for (genvar p = 0; p < int'(NUM_RP); p++) begin : g_rp
        wb_bypass_mux #(
            .NUM_CH (NUM_CH),
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
        ) u_bypass (
            .commit  (commit),
            .rd      (wb_rd),
            .value   (value),
            .addr    (rp_addr[p]),
            .rf_data (rf_rdata[p]),
            .data    (rp_data[p])
        );
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + 64'(popcount4(WB_MAX_CH'(commit)));
        end
    end

    assign wb_retired = retired_q;
`endif

endmodule

// File: tb/tb_wb_multiport_regfile.sv
// Scoreboard bench for wb_multiport_regfile (NUM_CH=2, NUM_RP=2, XLEN=64, 32 registers).
module tb_wb_multiport_regfile;

    logic                 clk;
    logic                 reset;
    logic                 memwb_ready;
    logic [1:0]           wb_valid;
    logic [1:0][4:0]      wb_rd;
    logic [1:0][63:0]     wb_aluresult;
    logic [1:0][63:0]     wb_loaddata;
    logic [1:0]           wb_dataselect;
    logic [1:0][4:0]      rp_addr;
    logic [1:0][63:0]     rp_data;
    logic [1:0]           wbex_valid;
    logic [1:0][4:0]      wbex_rd;
    logic [1:0][63:0]     wbex_rdval;
    logic                 wb_conflict;
    logic [63:0]          wb_retired;

    wb_multiport_regfile dut (
`ifdef WB_RETIRE_CNT_EN
        .wb_retired    (wb_retired),
`endif
        .clk           (clk),
        .reset         (reset),
        .memwb_ready   (memwb_ready),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_aluresult  (wb_aluresult),
        .wb_loaddata   (wb_loaddata),
        .wb_dataselect (wb_dataselect),
        .rp_addr       (rp_addr),
        .rp_data       (rp_data),
        .wbex_valid    (wbex_valid),
        .wbex_rd       (wbex_rd),
        .wbex_rdval    (wbex_rdval),
        .wb_conflict   (wb_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       valid;
        logic [1:0][4:0]  rd;
        logic [1:0][63:0] rdval;
        logic             conflict;
        logic [63:0]      retired;
    } exp_t;

    exp_t             sb[$];
    logic [63:0]      model_rf [32];
    logic [1:0][4:0]  model_rd;
    logic [1:0][63:0] model_rdval;
    logic [63:0]      model_ret;
    bit               rf_known;
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic rst_n, input logic ready, input logic [1:0] v,
                         input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [63:0] alu0, input logic [63:0] alu1,
                         input logic [63:0] ld0, input logic [63:0] ld1,
                         input logic [1:0] sel, input logic [4:0] ra0, input logic [4:0] ra1);
        logic [1:0]       cm;
        logic [1:0][63:0] val;
        logic [63:0]      exp_rp;
        exp_t             e;
        exp_t             got;
        @(negedge clk);
        reset            = rst_n;
        memwb_ready      = ready;
        wb_valid         = v;
        wb_rd[0]         = rd0;
        wb_rd[1]         = rd1;
        wb_aluresult[0]  = alu0;
        wb_aluresult[1]  = alu1;
        wb_loaddata[0]   = ld0;
        wb_loaddata[1]   = ld1;
        wb_dataselect    = sel;
        rp_addr[0]       = ra0;
        rp_addr[1]       = ra1;
        #2;
        for (int c = 0; c < 2; c++) begin
            cm[c]  = rst_n && ready && v[c];
            val[c] = (wb_rd[c] == 5'd0) ? 64'd0 : (sel[c] ? wb_loaddata[c] : wb_aluresult[c]);
        end
        if (rf_known) begin
            for (int p = 0; p < 2; p++) begin
                exp_rp = (rp_addr[p] == 5'd0) ? 64'd0 : model_rf[rp_addr[p]];
                for (int c = 0; c < 2; c++) begin
                    if (cm[c] && wb_rd[c] == rp_addr[p] && rp_addr[p] != 5'd0) exp_rp = val[c];
                end
                check($sformatf("rp_data[%0d]", p), rp_data[p], exp_rp);
            end
        end
        if (!rst_n) begin
            model_rd    = '0;
            model_rdval = '0;
            model_ret   = '0;
            e.valid     = '0;
            e.conflict  = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (cm[c]) begin
                    model_rd[c]    = wb_rd[c];
                    model_rdval[c] = val[c];
                end
            end
            model_ret  = model_ret + 64'(cm[0]) + 64'(cm[1]);
            e.valid    = cm;
            e.conflict = cm[0] && cm[1] && (rd0 == rd1) && (rd0 != 5'd0);
        end
        e.rd      = model_rd;
        e.rdval   = model_rdval;
        e.retired = model_ret;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("wbex_valid", 64'(wbex_valid), 64'(got.valid));
        for (int c = 0; c < 2; c++) begin
            check($sformatf("wbex_rd[%0d]", c), 64'(wbex_rd[c]), 64'(got.rd[c]));
            check($sformatf("wbex_rdval[%0d]", c), wbex_rdval[c], got.rdval[c]);
        end
        check("wb_conflict", 64'(wb_conflict), 64'(got.conflict));
`ifdef WB_RETIRE_CNT_EN
        check("wb_retired", wb_retired, got.retired);
`endif
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) model_rf[r] = 64'd0;
            rf_known = 1'b1;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (cm[c] && wb_rd[c] != 5'd0) model_rf[wb_rd[c]] = val[c];
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rf_known    = 1'b0;
        model_rd    = '0;
        model_rdval = '0;
        model_ret   = '0;
        for (int r = 0; r < 32; r++) model_rf[r] = 64'd0;

        // Reset with all channels valid: nothing may commit.
        cycle(1'b0, 1'b1, 2'b11, 5'd5, 5'd6, 64'h1, 64'h2, 64'h3, 64'h4, 2'b00, 5'd5, 5'd6);
        cycle(1'b0, 1'b1, 2'b11, 5'd5, 5'd6, 64'h1, 64'h2, 64'h3, 64'h4, 2'b00, 5'd5, 5'd6);
        // Single commit with same-cycle bypass, then storage read.
        cycle(1'b1, 1'b1, 2'b01, 5'd5, 5'd0, 64'hDEAD, 64'h0, 64'h0, 64'h0, 2'b00, 5'd5, 5'd6);
        cycle(1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 5'd5, 5'd0);
        // Same-rd collision: channel 1 wins.
        cycle(1'b1, 1'b1, 2'b11, 5'd7, 5'd7, 64'h11, 64'h22, 64'h0, 64'h0, 2'b00, 5'd7, 5'd5);
        cycle(1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 5'd7, 5'd5);
        // Load into x0.
        cycle(1'b1, 1'b1, 2'b10, 5'd9, 5'd0, 64'h0, 64'h0, 64'h0, 64'hFFFF, 2'b10, 5'd0, 5'd7);
        // Stall: nothing commits, forwarding values hold.
        cycle(1'b1, 1'b0, 2'b01, 5'd3, 5'd0, 64'h5, 64'h0, 64'h0, 64'h0, 2'b00, 5'd3, 5'd0);
        cycle(1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 5'd3, 5'd7);
        // Retire count sequence: reset, 3x both, 1x ch0 only.
        cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 2'b11, 5'(i + 1), 5'd0, 64'(i + 100), 64'h0, 64'hA, 64'hB, 2'b10,
                  5'(i + 1), 5'd0);
        end
        cycle(1'b1, 1'b1, 2'b01, 5'd4, 5'd8, 64'h44, 64'h88, 64'h0, 64'h0, 2'b00, 5'd4, 5'd1);
`ifdef WB_RETIRE_CNT_EN
        check("wb_retired_seq", wb_retired, 64'd7);
`endif
        // Random traffic over a small register window to provoke collisions.
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 31) != 0), ($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_multiport_regfile.md
# wb_multiport_regfile

Parametrised writeback stage and integrated register file for the RISC-V pipeline. Accepts NUM_CH independent writeback channels from MEM/WB per cycle, selects ALU or load data per channel, commits to a NUM_REGS × XLEN register file with x0 hardwired to zero, and drives registered per-channel forwarding to EX. Decode read ports see same-cycle writes through internal bypass.

## Interface
- NUM_CH, 2, writeback channels per cycle, 1..4
- NUM_RP, 2, combinational register read ports
- XLEN, 64, data width
- NUM_REGS, 32, architectural registers, power of two
- REG_AW, $clog2(NUM_REGS), register index width, derived
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- memwb_ready  in  1  MEM/WB stage holds valid data; 0 blocks all commits this cycle
- wb_valid  in  NUM_CH  channel c carries a writeback
- wb_rd  in  NUM_CH×REG_AW  destination register per channel
- wb_aluresult  in  NUM_CH×XLEN  ALU result per channel
- wb_loaddata  in  NUM_CH×XLEN  load data per channel
- wb_dataselect  in  NUM_CH  0 = ALU result, 1 = load data
- rp_addr  in  NUM_RP×REG_AW  read addresses
- rp_data  out  NUM_RP×XLEN  read data, combinational
- wbex_valid  out  NUM_CH  registered: channel c committed last cycle
- wbex_rd  out  NUM_CH×REG_AW  registered destination
- wbex_rdval  out  NUM_CH×XLEN  registered committed value
- wb_conflict  out  1  registered: ≥2 committing channels targeted same nonzero rd last cycle

## Operation
- Channel c commits when reset=1, memwb_ready=1, wb_valid[c]=1. Value = wb_dataselect[c] ? wb_loaddata[c] : wb_aluresult[c].
- wb_rd=0: commit counts as committed for forwarding (wbex_valid=1, wbex_rdval=0) but register file is untouched; x0 always reads 0.
- Same-rd collision in one cycle: highest-index channel (youngest in program order) wins register file write; lower channels still report their own value on wbex_*; wb_conflict=1 next cycle.
- rp_data[p]: 0 if rp_addr=0; else value of highest-index committing channel with matching wb_rd this cycle; else register file content.
- memwb_ready=0: no register file write, wbex_valid cleared to 0 next cycle, wbex_rd/wbex_rdval hold.

## Timing
- Register file write visible in storage at rising edge after commit cycle; visible on rp_data in the commit cycle via bypass (zero-latency read-after-write).
- wbex_* and wb_conflict: one-cycle latency from commit cycle.
- Reset (reset=0 at edge): all registers ← 0, wbex_valid ← 0, wbex_rd ← 0, wbex_rdval ← 0, wb_conflict ← 0, retire counter ← 0. Commits presented in a reset cycle are dropped; rp_data bypass is suppressed while reset=0.
- No state machine; pure pipelined storage. Throughput NUM_CH commits per cycle, no backpressure.

## Configuration
- WB_RETIRE_CNT_EN defined: adds output wb_retired (64 bits), a counter incremented each cycle by popcount of committing channels (including rd=0); wraps modulo 2^64; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package wb_pkg: XLEN/NUM_REGS defaults, typedef wb_chan_t (valid, rd, aluresult, loaddata, dataselect), typedef wb_fwd_t (valid, rd, rdval).
- One sub-module: wb_bypass_mux — per read port priority match over channels, reused by NUM_RP instances.

## Test plan
- Reset: hold reset=0 two cycles with wb_valid=all-1 → all rp_data=0, wbex_valid=0, no register written.
- Single commit: ch0 rd=5, ALU=0xDEAD, select=0 → rp_addr=5 reads 0xDEAD same cycle; next cycle wbex_valid[0]=1, wbex_rdval[0]=0xDEAD; storage holds 0xDEAD.
- Collision: ch0 rd=7 val=0x11, ch1 rd=7 val=0x22 → rp_data=0x22, register 7=0x22, wb_conflict=1 next cycle, wbex_rdval = {0x22, 0x11}.
- x0: ch1 rd=0, load=0xFFFF, select=1 → register 0 reads 0; wbex_valid[1]=1, wbex_rdval[1]=0.
- Stall: memwb_ready=0 with ch0 rd=3 val=0x5 → register 3 unchanged, wbex_valid=0, wbex_rdval holds prior value.
- WB_RETIRE_CNT_EN: 3 cycles of both channels valid, then 1 cycle ch0 only → wb_retired=7.
